// File: rtl/instr_fetch_responder_pkg.sv
// instr_fetch_responder_pkg: shared state encoding, NOP and RV32I opcodes for the fetch path
package instr_fetch_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [31:0] NOP          = 32'h00000013;
    localparam logic [6:0]  OPC_LUI      = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [6:0]  OPC_JALR     = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPC_STORE    = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OPC_OP       = 7'b0110011;
    localparam logic [6:0]  OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
    // misaligned byte address or word index beyond the array
    function automatic logic addr_err(input logic [31:0] a, input logic [31:0] depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
    endfunction
endpackage

// File: rtl/instr_fetch_responder_if.sv
// instr_fetch_responder_if: CPU fetch request/response handshake bundle
interface instr_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_err);
    modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/instr_mem_array.sv
// instr_mem_array: DEPTHx32 program array, one write port, synchronous read-before-write
module instr_mem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: fixed-latency instruction fetch responder with a program load port
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_responder_if.slave   fetch,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr;
    logic [31:0] mem_q;
    logic        capture;
    logic        err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && fetch.req_valid) addr <= fetch.req_addr;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: if (fetch.req_valid) begin
                state_nxt = WAIT;
                cnt_nxt   = 4'(LATENCY - 1);
            end
            WAIT: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                  else begin
                      capture   = 1'b1;
                      state_nxt = RESP;
                  end
            RESP: if (fetch.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // the memory's read register is the response data holder; it only loads on capture
    instr_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (capture),
        .raddr (addr[AW+1:2]),
        .rdata (mem_q)
    );
    assign err             = addr_err(addr, 32'(DEPTH));
    assign fetch.req_ready = state == IDLE;
    assign fetch.rsp_valid = state == RESP;
    assign fetch.rsp_err   = fetch.rsp_valid && err;
    assign fetch.rsp_data  = !fetch.rsp_valid ? '0 : err ? NOP : mem_q;
    assign busy            = state != IDLE;
endmodule
